// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encoding, opcode classes and widths for the 8-bit CPU sequencer
package cpu_pkg;
  localparam int PC_W = 8;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_JUMP = 2'b11;
  localparam logic [7:0] HALT_OPCODE = 8'hFF;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, HALT} state_e;
endpackage

// File: rtl/fetch_exec_sequencer_if.sv
// fetch_exec_sequencer_if: bundles run, imem req/ack/addr/data and datapath instr/reg_we/wb_stall/pc/status signals; master = sequencer, slave = memory+datapath
interface fetch_exec_sequencer_if;
  import cpu_pkg::*;
  logic run, imem_req, imem_ack, reg_we, wb_stall, fetch_err, halted;
  logic [PC_W-1:0] imem_addr, pc;
  logic [7:0] imem_data, instr;
  modport master(input run, imem_ack, imem_data, wb_stall,
                 output imem_req, imem_addr, instr, reg_we, pc, fetch_err, halted);
  modport slave(output run, imem_ack, imem_data, wb_stall,
                input imem_req, imem_addr, instr, reg_we, pc, fetch_err, halted);
endinterface

// File: rtl/pc_next_calc.sv
// pc_next_calc: next PC = pc+1, or pc+sext(instr[5:0]) for jumps (mod 256); ports pc, instr in, pc_next out
module pc_next_calc
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic [7:0]      instr,
  output logic [PC_W-1:0] pc_next
);
  assign pc_next = pc + ((instr[7:6] == OP_JUMP) ? {{2{instr[5]}}, instr[5:0]} : 8'd1);
endmodule

// File: rtl/fetch_exec_sequencer.sv
// fetch_exec_sequencer: multi-cycle fetch/exec/writeback sequencer; ports clk, rst, bus (fetch_exec_sequencer_if.master); CPU_HALT_EN enables the HALT state
module fetch_exec_sequencer
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00,
  parameter int FETCH_TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  fetch_exec_sequencer_if.master bus
);
  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_FETCH = FETCH;
  localparam logic [2:0] S_EXEC = EXEC;
  localparam logic [2:0] S_WB = WB;
  localparam logic [2:0] S_HALT = HALT;
  localparam logic [15:0] TO = 16'(FETCH_TIMEOUT);
`ifdef CPU_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif
  logic [2:0] state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_nx;
  logic [7:0] instr_q, instr_d;
  logic err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic is_halt, timeout;
  pc_next_calc u_pc (.pc(pc_q), .instr(instr_q), .pc_next(pc_nx));
  assign is_halt = instr_q == HALT_OPCODE;
  assign timeout = (FETCH_TIMEOUT != 0) && (cnt_q == TO);
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    err_d = err_q;
    // counts cycles spent in FETCH; any other state leaves it at zero for the next entry
    cnt_d = (state_q == S_FETCH) ? cnt_q + 16'd1 : '0;
    case (state_q)
      S_IDLE: state_d = (bus.run && !err_q) ? S_FETCH : S_IDLE;
      S_FETCH:
        if (bus.imem_ack) begin
          instr_d = bus.imem_data;
          state_d = S_EXEC;
        end else if (timeout) begin
          err_d = 1'b1;
          state_d = S_IDLE;
        end
      S_EXEC:
        if (instr_q[7:6] == OP_WRITE) state_d = S_WB;
        else if (HALT_EN && is_halt) state_d = S_HALT;
        else begin
          // 8'hFF without HALT is a jump-to-self: the PC is kept rather than stepped back
          pc_d = is_halt ? pc_q : pc_nx;
          state_d = bus.run ? S_FETCH : S_IDLE;
        end
      S_WB:
        if (!bus.wb_stall) begin
          pc_d = pc_nx;
          state_d = bus.run ? S_FETCH : S_IDLE;
        end
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q <= RESET_PC;
      instr_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.imem_req = state_q == S_FETCH;
  assign bus.imem_addr = pc_q;
  assign bus.pc = pc_q;
  assign bus.instr = instr_q;
  assign bus.reg_we = state_q == S_WB;
  assign bus.fetch_err = err_q;
  assign bus.halted = HALT_EN && (state_q == S_HALT);
endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// tb_fetch_exec_sequencer: randomized and directed checks of fetch_exec_sequencer against an instruction-level model
module tb_fetch_exec_sequencer;
  import cpu_pkg::*;
  localparam int TO = 15;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int exp_pc = 0;
  fetch_exec_sequencer_if bus();
  fetch_exec_sequencer #(.RESET_PC(8'h00), .FETCH_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic int model_next(input int pc, input int d);
    int off;
    if (d[7:6] != 2'b11) return (pc + 1) & 255;
    if (d == 255) return pc;
    off = d[5] ? int'(d[5:0]) - 64 : int'(d[5:0]);
    return (pc + off) & 255;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.run = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_data = 8'h00;
    bus.wb_stall = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_pc = 0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.imem_req && n < 20) begin
      step();
      n++;
    end
    chk("req_wait", bus.imem_req, 1);
  endtask

  // one instruction: ack after dly cycles with data d, hold wb_stall for k WB cycles
  task automatic do_instr(input logic [7:0] d, input int dly, input int k, input logic run_after);
    int c, we_cnt, limit;
    wait_req();
    chk("addr", bus.imem_addr, exp_pc);
    chk("pc", bus.pc, exp_pc);
    for (int i = 0; i < dly; i++) begin
      step();
      chk("req_hold", bus.imem_req, 1);
    end
    bus.imem_ack = 1'b1;
    bus.imem_data = d;
    bus.run = run_after;
    step();
    bus.imem_ack = 1'b0;
    bus.imem_data = 8'($urandom);
    chk("instr", bus.instr, d);
    c = 1;
    we_cnt = 0;
    limit = run_after ? 40 : 8 + k;
    while (!bus.imem_req && c < limit) begin
      bus.wb_stall = (c >= 2) && (c < 2 + k);
      we_cnt += int'(bus.reg_we);
      step();
      c++;
    end
    bus.wb_stall = 1'b0;
    if (run_after) chk("gap", c, (d[7:6] == 2'b10) ? 3 + k : 2);
    else chk("idle_req", bus.imem_req, 0);
    chk("we_cnt", we_cnt, (d[7:6] == 2'b10) ? k + 1 : 0);
    chk("fetch_err", bus.fetch_err, 0);
    exp_pc = model_next(exp_pc, int'(d));
    if (!run_after) chk("idle_pc", bus.pc, exp_pc);
    bus.run = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] d;
    do_reset();
    chk("rst_req", bus.imem_req, 0);
    chk("rst_we", bus.reg_we, 0);
    chk("rst_pc", bus.pc, 8'h00);
    chk("rst_instr", bus.instr, 0);
    chk("rst_err", bus.fetch_err, 0);
    chk("rst_halted", bus.halted, 0);
    bus.run = 1'b1;
    do_instr(8'h10, 0, 0, 1'b1);
    do_instr(8'h20, 0, 0, 1'b1);
    chk("addr_2", bus.imem_addr, 8'h02);
    do_reset();
    bus.run = 1'b1;
    do_instr(8'h85, 0, 2, 1'b1);
    chk("addr_after_wb", bus.imem_addr, 8'h01);
    do_reset();
    bus.run = 1'b1;
    do_instr(8'h00, 0, 0, 1'b1);
    do_instr(8'h00, 0, 0, 1'b1);
    do_instr(8'hFC, 0, 0, 1'b1);
    chk("addr_fe", bus.imem_addr, 8'hFE);
    do_instr(8'h00, 1, 0, 1'b1);
    do_instr(8'h00, 0, 0, 1'b1);
    chk("addr_wrap", bus.imem_addr, 8'h00);
    do_instr(8'h3F, TO, 0, 1'b1);
    do_reset();
    bus.run = 1'b1;
    step();
    n = 0;
    while (bus.imem_req && n < 40) begin
      step();
      n++;
    end
    chk("to_cycles", n, TO + 1);
    chk("to_err", bus.fetch_err, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("to_locked", bus.imem_req, 0);
    end
    do_reset();
    chk("to_cleared", bus.fetch_err, 0);
    bus.run = 1'b1;
    for (int i = 0; i < 7; i++) do_instr(8'h01, 0, 0, 1'b1);
`ifdef CPU_HALT_EN
    wait_req();
    chk("halt_addr", bus.imem_addr, 8'h07);
    bus.imem_ack = 1'b1;
    bus.imem_data = 8'hFF;
    step();
    bus.imem_ack = 1'b0;
    step();
    chk("halted", bus.halted, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_req", bus.imem_req, 0);
      chk("halt_pc", bus.pc, 8'h07);
    end
`else
    do_instr(8'hFF, 0, 0, 1'b1);
    chk("self_addr", bus.imem_addr, 8'h07);
    do_instr(8'hFF, 0, 0, 1'b1);
    chk("self_addr2", bus.imem_addr, 8'h07);
    chk("no_halt", bus.halted, 0);
`endif
    do_reset();
    bus.run = 1'b1;
    do_instr(8'h01, 0, 0, 1'b1);
    do_instr(8'h02, 0, 0, 1'b1);
    wait_req();
    bus.imem_ack = 1'b1;
    bus.imem_data = 8'h85;
    step();
    bus.imem_ack = 1'b0;
    bus.wb_stall = 1'b1;
    step();
    chk("wb_we", bus.reg_we, 1);
    rst = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_data = 8'hC3;
    step();
    chk("rwb_req", bus.imem_req, 0);
    chk("rwb_we", bus.reg_we, 0);
    chk("rwb_pc", bus.pc, 8'h00);
    chk("rwb_instr", bus.instr, 0);
    chk("rwb_err", bus.fetch_err, 0);
    chk("rwb_halted", bus.halted, 0);
    do_reset();
    bus.run = 1'b1;
    for (int i = 0; i < 60; i++) begin
      d = 8'($urandom);
      if (d == 8'hFF) d = 8'hFE;
      do_instr(d, ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), $urandom_range(0, 7) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
